mprj_io_arbiter: RTL and testbench
==================================

# mprj_io_arbiter

Shares the user-project GPIO output bank (io_out/io_oeb, normally mprj_io[7:0]) among several internal requesters: Wishbone-driven firmware port, logic-analyzer override, pattern engine. Round-robin grant, bounded hold time, one-cycle tristate turnaround between owners, so two sources never drive the pads in the same cycle. Sits in user_project_wrapper between the requesters and the io_out/io_oeb pad bus.

## Interface
- N_REQ, 3: number of requesters (2..8).
- WIDTH, 8: pad bits arbitrated.
- MAX_HOLD, 1024: max consecutive grant cycles per ownership (>=2).
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- req_i  in  N_REQ  request per requester; held while ownership wanted.
- data_i  in  N_REQ*WIDTH  requester output values; slice k = requester k.
- oeb_i  in  N_REQ*WIDTH  requester output-enable-bar; slice k = requester k.
- gnt_o  out  N_REQ  one-hot grant, registered.
- io_out  out  WIDTH  pad output value, registered.
- io_oeb  out  WIDTH  pad output-enable-bar, registered (1 = tristate).
- busy_o  out  1  high while state is GRANT.
- owner_o  out  3  index of current/last owner.
- timeout_o  out  1  one-cycle pulse on forced release.

## Operation
- States: IDLE, GRANT, TURN.
- IDLE: if any eligible req -> GRANT with round-robin winner; else stay.
- Eligible = req_i[k] & ~penalty[k].
- Round-robin: search starts at (last_owner+1) mod N_REQ, wraps; after reset last_owner = N_REQ-1, so requester 0 wins first.
- GRANT: owner keeps grant while req high and hold_cnt < MAX_HOLD-1.
  - Owner drops req -> TURN.
  - hold_cnt == MAX_HOLD-1 with req still high -> TURN, timeout_o pulse, penalty[owner] set.
- TURN: exactly one cycle, gnt_o=0; then GRANT if any eligible req (round-robin), else IDLE.
- penalty[k] clears the cycle after req_i[k] is sampled low; penalised requester is never granted.
- Non-owner req changes during GRANT ignored.
- hold_cnt: clog2(MAX_HOLD) bits, cleared on GRANT entry, +1 per GRANT cycle, never wraps.
- Pad registers: on every edge where current and next state are both GRANT, io_out <= data_i[owner], io_oeb <= oeb_i[owner]; on every other edge io_out <= 0, io_oeb <= all ones.
- Reset values: state IDLE, gnt_o 0, io_out 0, io_oeb all ones, busy_o 0, owner_o 0, timeout_o 0, penalty 0, hold_cnt 0.
- Reset mid-GRANT: next cycle all outputs at reset values, pads tristated, grant lost without timeout pulse.

## Timing
- req_i rises at edge t in IDLE -> gnt_o/busy_o/owner_o valid after t+1.
- Pads reflect data_i sampled at t+1 after edge t+2; thereafter 1-cycle pass-through latency.
- Owner drops req at edge e -> gnt_o=0, io_oeb all ones after e; next owner gnt_o after e+1, drives pads after e+2.
- Minimum gap between two owners driving: 1 full tristate cycle.
- Max ownership: MAX_HOLD gnt_o cycles; timeout_o high in the first TURN cycle.
- Owner release and another req in same cycle: TURN still inserted.

## Structure
- Shared package mprj_io_pkg: state enum (IDLE/GRANT/TURN), IO_IDLE_OEB constant (all ones), owner index width.
- Sub-module rr_pick: combinational round-robin picker (eligible vector + last owner -> winner index, valid).
- Top: FSM, hold counter, penalty mask, pad output registers.

## Test plan
- Single req0 writes 8'h01..8'h0A, 8'hFF, 8'h00 with oeb_i=0 -> io_out shows same sequence 1 cycle late, io_oeb=8'h00 while granted, 8'hFF otherwise.
- req0..2 all high, each holds 4 cycles -> grant order 0,1,2,0; exactly one TURN cycle (io_oeb=8'hFF, gnt_o=0) between owners.
- MAX_HOLD=16, req1 held forever -> gnt_o[1] high 16 cycles, timeout_o pulse, req1 not regranted until it drops and reasserts; req2 granted meanwhile if requesting.
- wb_rst_i asserted mid-GRANT -> next cycle gnt_o=0, io_out=0, io_oeb=8'hFF, no timeout pulse; after release, req2 alone -> granted requester 2, owner_o=2.
- Owner0 drops req in same cycle req1 rises -> TURN cycle, gnt_o[1] one cycle later, io_out = data_i[1] one cycle after that.
- Requester with oeb_i=8'hF0 -> io_oeb=8'hF0 while granted, upper nibble tristate, 8'hFF after release.

Source files
------------

// File: rtl/mprj_io_arbiter_pkg.sv
// Shared types and constants for the user-project GPIO bank arbiter.
package mprj_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Owner index width covers up to 8 requesters
    localparam int unsigned OWNER_W   = 3;
    // Widest pad bank supported; users slice IO_IDLE_OEB down to their width
    localparam int unsigned MAX_PAD_W = 32;
    localparam logic [MAX_PAD_W-1:0] IO_IDLE_OEB = '1;

endpackage

// File: rtl/mprj_io_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester after last_owner.
module rr_pick
    import mprj_io_pkg::*;
#(
    parameter int unsigned N_REQ = 3
) (
    input  logic [N_REQ-1:0]   eligible,
    input  logic [OWNER_W-1:0] last_owner,
    output logic [OWNER_W-1:0] winner,
    output logic               valid
);

    // Scan offsets from farthest to nearest so the nearest eligible one wins
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int off = int'(N_REQ); off >= 1; off--) begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                if (eligible[k] && (k == ((int'(last_owner) + off) % int'(N_REQ)))) begin
                    winner = OWNER_W'(k);
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mprj_io_arbiter.sv
// Round-robin owner of the GPIO output bank with bounded hold and tristate turnaround.
module mprj_io_arbiter
    import mprj_io_pkg::*;
#(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 1024
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*WIDTH-1:0]   data_i,
    input  logic [N_REQ*WIDTH-1:0]   oeb_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [WIDTH-1:0]         io_out,
    output logic [WIDTH-1:0]         io_oeb,
    output logic                     busy_o,
    output logic [OWNER_W-1:0]       owner_o,
    output logic                     timeout_o
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [WIDTH-1:0] IDLE_OEB = IO_IDLE_OEB[WIDTH-1:0];

    state_t               state, state_nxt;
    logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
    logic [OWNER_W-1:0]   last_owner, last_nxt, owner_nxt;
    logic [N_REQ-1:0]     penalty, penalty_set, gnt_nxt, eligible;
    logic                 timeout_nxt;
    logic                 own_req;
    logic [WIDTH-1:0]     own_data, own_oeb;
    logic [OWNER_W-1:0]   pick_winner;
    logic                 pick_valid;

    assign eligible = req_i & ~penalty;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .eligible   (eligible),
        .last_owner (last_owner),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    // Select the current owner's request and pad values
    always_comb begin
        own_req  = 1'b0;
        own_data = '0;
        own_oeb  = IDLE_OEB;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (owner_o == OWNER_W'(k)) begin
                own_req  = req_i[k];
                own_data = data_i[k*WIDTH +: WIDTH];
                own_oeb  = oeb_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next state, grant, hold counter and forced-release decision
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        owner_nxt   = owner_o;
        last_nxt    = last_owner;
        gnt_nxt     = gnt_o;
        timeout_nxt = 1'b0;
        penalty_set = '0;
        unique case (state)
            IDLE, TURN: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                if (pick_valid) begin
                    state_nxt = GRANT;
                    gnt_nxt   = N_REQ'(1) << pick_winner;
                    owner_nxt = pick_winner;
                    last_nxt  = pick_winner;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    state_nxt = TURN;
                    gnt_nxt   = '0;
                end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                    state_nxt   = TURN;
                    gnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                    penalty_set = N_REQ'(1) << owner_o;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // Registered outputs, penalty mask and pads (pads only driven mid-ownership)
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            hold_cnt   <= '0;
            gnt_o      <= '0;
            busy_o     <= 1'b0;
            owner_o    <= '0;
            last_owner <= OWNER_W'(N_REQ - 1);
            timeout_o  <= 1'b0;
            penalty    <= '0;
            io_out     <= '0;
            io_oeb     <= IDLE_OEB;
        end else begin
            hold_cnt   <= hold_nxt;
            gnt_o      <= gnt_nxt;
            busy_o     <= (state_nxt == GRANT);
            owner_o    <= owner_nxt;
            last_owner <= last_nxt;
            timeout_o  <= timeout_nxt;
            penalty    <= (penalty & req_i) | penalty_set;
            if (state == GRANT && state_nxt == GRANT) begin
                io_out <= own_data;
                io_oeb <= own_oeb;
            end else begin
                io_out <= '0;
                io_oeb <= IDLE_OEB;
            end
        end
    end

endmodule

// File: tb/tb_mprj_io_arbiter.sv
// Directed scoreboard bench for mprj_io_arbiter (N_REQ=3, WIDTH=8, MAX_HOLD=16).
module tb_mprj_io_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [2:0]  req_i;
    logic [23:0] data_i;
    logic [23:0] oeb_i;
    logic [2:0]  gnt_o;
    logic [7:0]  io_out;
    logic [7:0]  io_oeb;
    logic        busy_o;
    logic [2:0]  owner_o;
    logic        timeout_o;

    typedef struct packed {
        logic [2:0] gnt;
        logic       busy;
        logic [2:0] own;
        logic       to;
        logic [7:0] out;
        logic [7:0] oeb;
    } exp_t;

    exp_t exp_q[$];
    int   tag_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec    = 0;

    mprj_io_arbiter #(.N_REQ(3), .WIDTH(8), .MAX_HOLD(16)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .req_i     (req_i),
        .data_i    (data_i),
        .oeb_i     (oeb_i),
        .gnt_o     (gnt_o),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .busy_o    (busy_o),
        .owner_o   (owner_o),
        .timeout_o (timeout_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Drive one cycle of inputs, then queue the outputs expected after that edge
    task automatic cyc(input logic rst, input logic [2:0] req,
                       input logic [2:0] g, input logic b, input logic [2:0] o,
                       input logic t, input logic [7:0] out, input logic [7:0] oeb);
        exp_t e;
        wb_rst_i = rst;
        req_i    = req;
        @(posedge wb_clk_i);
        e.gnt = g; e.busy = b; e.own = o; e.to = t; e.out = out; e.oeb = oeb;
        exp_q.push_back(e);
        tag_q.push_back(vec);
        vec++;
        #1;
    endtask

    // Monitor: pop and compare on the falling edge after each queued edge
    always @(negedge wb_clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            int   tg;
            e = exp_q.pop_front();
            tg = tag_q.pop_front();
            a.gnt = gnt_o; a.busy = busy_o; a.own = owner_o; a.to = timeout_o;
            a.out = io_out; a.oeb = io_oeb;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL vec%0d got gnt=%b busy=%b own=%0d to=%b out=%h oeb=%h want gnt=%b busy=%b own=%0d to=%b out=%h oeb=%h",
                         tg, a.gnt, a.busy, a.own, a.to, a.out, a.oeb,
                         e.gnt, e.busy, e.own, e.to, e.out, e.oeb);
            end
        end
    end

    initial begin
        logic [7:0] seq [12];
        int         n;
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                8'h09, 8'h0A, 8'hFF, 8'h00};
        wb_rst_i = 1'b1;
        req_i    = 3'b000;
        data_i   = {8'h33, 8'h22, 8'h11};
        oeb_i    = 24'h000000;

        // Reset state
        cyc(1, 3'b000, 3'b000, 0, 0, 0, 8'h00, 8'hFF);
        cyc(1, 3'b000, 3'b000, 0, 0, 0, 8'h00, 8'hFF);

        // Single requester 0: pass-through with one cycle of latency
        data_i[7:0] = 8'h00;
        cyc(0, 3'b001, 3'b001, 1, 0, 0, 8'h00, 8'hFF);
        for (int i = 0; i < 12; i++) begin
            data_i[7:0] = seq[i];
            cyc(0, 3'b001, 3'b001, 1, 0, 0, seq[i], 8'h00);
        end
        cyc(0, 3'b000, 3'b000, 0, 0, 0, 8'h00, 8'hFF);
        cyc(0, 3'b000, 3'b000, 0, 0, 0, 8'h00, 8'hFF);
        data_i[7:0] = 8'h11;

        // Reset, then all three request: order 0,1,2,0 with one TURN between owners
        cyc(1, 3'b000, 3'b000, 0, 0, 0, 8'h00, 8'hFF);
        cyc(0, 3'b111, 3'b001, 1, 0, 0, 8'h00, 8'hFF);
        for (int i = 0; i < 3; i++) cyc(0, 3'b111, 3'b001, 1, 0, 0, 8'h11, 8'h00);
        cyc(0, 3'b110, 3'b000, 0, 0, 0, 8'h00, 8'hFF);
        cyc(0, 3'b110, 3'b010, 1, 1, 0, 8'h00, 8'hFF);
        for (int i = 0; i < 3; i++) cyc(0, 3'b111, 3'b010, 1, 1, 0, 8'h22, 8'h00);
        cyc(0, 3'b101, 3'b000, 0, 1, 0, 8'h00, 8'hFF);
        cyc(0, 3'b101, 3'b100, 1, 2, 0, 8'h00, 8'hFF);
        for (int i = 0; i < 3; i++) cyc(0, 3'b111, 3'b100, 1, 2, 0, 8'h33, 8'h00);
        cyc(0, 3'b011, 3'b000, 0, 2, 0, 8'h00, 8'hFF);
        cyc(0, 3'b011, 3'b001, 1, 0, 0, 8'h00, 8'hFF);
        cyc(0, 3'b011, 3'b001, 1, 0, 0, 8'h11, 8'h00);
        cyc(0, 3'b000, 3'b000, 0, 0, 0, 8'h00, 8'hFF);
        cyc(0, 3'b000, 3'b000, 0, 0, 0, 8'h00, 8'hFF);

        // Owner 0 drops while requester 1 rises: TURN still inserted
        cyc(0, 3'b001, 3'b001, 1, 0, 0, 8'h00, 8'hFF);
        cyc(0, 3'b001, 3'b001, 1, 0, 0, 8'h11, 8'h00);
        cyc(0, 3'b010, 3'b000, 0, 0, 0, 8'h00, 8'hFF);
        cyc(0, 3'b010, 3'b010, 1, 1, 0, 8'h00, 8'hFF);
        cyc(0, 3'b010, 3'b010, 1, 1, 0, 8'h22, 8'h00);
        cyc(0, 3'b000, 3'b000, 0, 1, 0, 8'h00, 8'hFF);
        cyc(0, 3'b000, 3'b000, 0, 1, 0, 8'h00, 8'hFF);

        // Partial output enable from requester 2
        oeb_i[23:16] = 8'hF0;
        cyc(0, 3'b100, 3'b100, 1, 2, 0, 8'h00, 8'hFF);
        cyc(0, 3'b100, 3'b100, 1, 2, 0, 8'h33, 8'hF0);
        cyc(0, 3'b000, 3'b000, 0, 2, 0, 8'h00, 8'hFF);
        cyc(0, 3'b000, 3'b000, 0, 2, 0, 8'h00, 8'hFF);
        oeb_i[23:16] = 8'h00;

        // Requester 1 held past MAX_HOLD: forced release and penalty
        cyc(0, 3'b010, 3'b010, 1, 1, 0, 8'h00, 8'hFF);
        for (int i = 0; i < 15; i++) cyc(0, 3'b010, 3'b010, 1, 1, 0, 8'h22, 8'h00);
        cyc(0, 3'b110, 3'b000, 0, 1, 1, 8'h00, 8'hFF);
        cyc(0, 3'b110, 3'b100, 1, 2, 0, 8'h00, 8'hFF);
        cyc(0, 3'b110, 3'b100, 1, 2, 0, 8'h33, 8'h00);
        cyc(0, 3'b010, 3'b000, 0, 2, 0, 8'h00, 8'hFF);
        cyc(0, 3'b010, 3'b000, 0, 2, 0, 8'h00, 8'hFF);
        cyc(0, 3'b010, 3'b000, 0, 2, 0, 8'h00, 8'hFF);
        cyc(0, 3'b000, 3'b000, 0, 2, 0, 8'h00, 8'hFF);
        cyc(0, 3'b010, 3'b010, 1, 1, 0, 8'h00, 8'hFF);
        cyc(0, 3'b010, 3'b010, 1, 1, 0, 8'h22, 8'h00);

        // Reset mid-GRANT, then requester 2 alone wins first
        cyc(1, 3'b010, 3'b000, 0, 0, 0, 8'h00, 8'hFF);
        cyc(0, 3'b100, 3'b100, 1, 2, 0, 8'h00, 8'hFF);
        cyc(0, 3'b100, 3'b100, 1, 2, 0, 8'h33, 8'h00);
        cyc(0, 3'b000, 3'b000, 0, 2, 0, 8'h00, 8'hFF);
        cyc(0, 3'b000, 3'b000, 0, 2, 0, 8'h00, 8'hFF);

        // Let the monitor drain, bounded
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge wb_clk_i);
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
